armv8_fetch_stage: RTL and testbench

//  Instruction-fetch front end for the pipelined ARMv8 core that follows singlecycle.
//  - Owns the PC and issues requests to a synchronous instruction memory with 1-cycle read latency.
//  - Buffers returned words in a small FIFO.
//  - Presents {pc, instr} to decode with a valid/ready handshake.
//  - Accepts branch redirects from execute and discards wrong-path fetches.

---
 rtl/armv8_fetch_stage_if.sv | 32 +++
 rtl/armv8_fetch_stage.sv | 112 +++++++++++
 tb/tb_armv8_fetch_stage.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/armv8_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input from execute,
// and the {pc, instr} valid/ready handshake toward decode.
interface armv8_fetch_stage_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               id_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect, redirect_pc,
    output if_valid, if_instr, if_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect, redirect_pc,
    input  if_valid, if_instr, if_pc,
    output id_ready
  );
endinterface

// File: rtl/armv8_fetch_stage.sv
// Instruction fetch front end: owns the PC, issues 1-cycle-latency imem reads,
// buffers responses in a small FIFO, and squashes wrong-path fetches on redirect.
module armv8_fetch_stage #(
  parameter int PC_W       = 64,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [PC_W-1:0]     startpc,
  armv8_fetch_stage_if.master fif,
  output logic [PC_W-1:0]     currentpc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t             state, state_nxt;
  logic               run;

  logic [PC_W-1:0]    pc;
  logic               epoch;

  logic               req_vld_p1;
  logic               req_epoch_p1;
  logic [PC_W-1:0]    req_pc_p1;

  logic [INSTR_W-1:0] fifo_instr [FIFO_DEPTH];
  logic [PC_W-1:0]    fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;

  logic               pop, push, issue;
  logic [CNT_W:0]     occupancy;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    run = 1'b0;
    case (state)
      RUN:     run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  // Occupancy counts the response still in flight, so a push can never hit a full buffer.
  always_comb begin
    fif.if_valid = (count != '0);
    pop          = fif.if_valid & fif.id_ready;
    occupancy    = {1'b0, count} + (CNT_W+1)'(req_vld_p1) - (CNT_W+1)'(pop);
    issue        = run & ~fif.redirect & (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    push         = req_vld_p1 & (req_epoch_p1 == epoch) & ~fif.redirect;
    fif.imem_req  = issue;
    fif.imem_addr = pc;
    fif.if_instr  = fif.if_valid ? fifo_instr[head] : '0;
    fif.if_pc     = fif.if_valid ? fifo_pc[head]    : '0;
    currentpc     = pc;
  end

  // Stage p0 -> p1: request issue, PC advance and buffer bookkeeping.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pc         <= startpc;
      epoch      <= 1'b0;
      req_vld_p1 <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else if (fif.redirect) begin
      pc         <= {fif.redirect_pc[PC_W-1:2], 2'b00};
      epoch      <= ~epoch;
      req_vld_p1 <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      req_vld_p1 <= issue;
      if (issue) pc   <= pc + PC_W'(4);
      if (push)  tail <= tail + PTR_W'(1);
      if (pop)   head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Stage p1 -> buffer: tag each request and capture the returned word.
  always_ff @(posedge CLK) begin
    req_pc_p1    <= pc;
    req_epoch_p1 <= epoch;
    if (push) begin
      fifo_instr[tail] <= fif.imem_rdata;
      fifo_pc[tail]    <= req_pc_p1;
    end
  end

  ovf_chk: assert property (@(posedge CLK) disable iff (reset)
    !(push && !pop && (count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_armv8_fetch_stage.sv
// Directed bench for armv8_fetch_stage: streaming, backpressure, redirects,
// PC wrap-around and mid-stream reset against a synchronous imem model.
module tb_armv8_fetch_stage;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  logic            CLK = 1'b0;
  logic            reset = 1'b1;
  logic [PC_W-1:0] startpc = '0;
  logic [PC_W-1:0] currentpc;
  int              nvec = 0;
  int              nerr = 0;

  armv8_fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  armv8_fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .FIFO_DEPTH(2)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .startpc   (startpc),
    .fif       (bus),
    .currentpc (currentpc)
  );

  always #5 CLK = ~CLK;

  // Memory image: each word encodes the low 24 bits of its own address.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    return 32'hE000_0000 | {8'h00, a[23:0]};
  endfunction

  always @(posedge CLK) begin
    if (bus.imem_req) bus.imem_rdata <= word_at(bus.imem_addr);
  end

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  // Leaves the bench one step after the edge that begins cycle 0 (BOOT).
  task automatic start(input logic [63:0] spc);
    reset = 1'b1;
    startpc = spc;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b1;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    startpc = 64'h1000;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b1;
    nxt();
    nxt();
    look();
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL rst_if_valid got %b want 0", bus.if_valid); end
    nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL rst_imem_req got %b want 0", bus.imem_req); end
    nvec++; if (bus.imem_addr !== 64'h1000) begin nerr++; $display("FAIL rst_imem_addr got %h want %h", bus.imem_addr, 64'h1000); end
    nvec++; if (currentpc !== 64'h1000) begin nerr++; $display("FAIL rst_currentpc got %h want %h", currentpc, 64'h1000); end
    nvec++; if (bus.if_pc !== 64'h0) begin nerr++; $display("FAIL rst_if_pc got %h want 0", bus.if_pc); end
    nvec++; if (bus.if_instr !== 32'h0) begin nerr++; $display("FAIL rst_if_instr got %h want 0", bus.if_instr); end
    nxt();
    reset = 1'b0;
    look();
    nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL boot_imem_req got %b want 0", bus.imem_req); end
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc;
    start(64'h0);
    look();
    nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL s_boot_req got %b want 0", bus.imem_req); end
    nxt(); look();
    nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin nerr++; $display("FAIL s_cyc1_req got %b/%h want 1/0", bus.imem_req, bus.imem_addr); end
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL s_cyc1_valid got %b want 0", bus.if_valid); end
    nxt(); look();
    nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h4) begin nerr++; $display("FAIL s_cyc2_req got %b/%h want 1/4", bus.imem_req, bus.imem_addr); end
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL s_cyc2_valid got %b want 0", bus.if_valid); end
    for (int k = 0; k < 6; k++) begin
      nxt(); look();
      exp_pc = 64'(4 * k);
      nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc) begin nerr++; $display("FAIL s_head%0d got %b/%h want 1/%h", k, bus.if_valid, bus.if_pc, exp_pc); end
      nvec++; if (bus.if_instr !== word_at(exp_pc)) begin nerr++; $display("FAIL s_instr%0d got %h want %h", k, bus.if_instr, word_at(exp_pc)); end
    end
  endtask

  // Continues from the end of test_stream (head 0x18 in the next cycle).
  task automatic test_backpressure();
    logic [63:0] exp_pc;
    for (int j = 0; j < 6; j++) begin
      nxt();
      if (j == 0) bus.id_ready = 1'b0;
      look();
      nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h18) begin nerr++; $display("FAIL bp_hold%0d got %b/%h want 1/18", j, bus.if_valid, bus.if_pc); end
      nvec++; if (bus.if_instr !== 32'hE000_0018) begin nerr++; $display("FAIL bp_instr%0d got %h want e0000018", j, bus.if_instr); end
      nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL bp_req%0d got %b want 0", j, bus.imem_req); end
    end
    for (int k = 0; k < 6; k++) begin
      nxt();
      if (k == 0) bus.id_ready = 1'b1;
      look();
      exp_pc = 64'h18 + 64'(4 * k);
      if (k == 0) begin
        nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h20) begin nerr++; $display("FAIL bp_resume_req got %b/%h want 1/20", bus.imem_req, bus.imem_addr); end
      end
      nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc) begin nerr++; $display("FAIL bp_seq%0d got %b/%h want 1/%h", k, bus.if_valid, bus.if_pc, exp_pc); end
      nvec++; if (bus.if_instr !== word_at(exp_pc)) begin nerr++; $display("FAIL bp_sinstr%0d got %h want %h", k, bus.if_instr, word_at(exp_pc)); end
    end
  endtask

  task automatic test_redirect_inflight();
    start(64'h0);
    repeat (5) nxt();
    look();
    nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h10) begin nerr++; $display("FAIL ri_pre_req got %b/%h want 1/10", bus.imem_req, bus.imem_addr); end
    nvec++; if (bus.if_pc !== 64'h8) begin nerr++; $display("FAIL ri_pre_head got %h want 8", bus.if_pc); end
    nxt();
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h43;
    look();
    nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL ri_r_req got %b want 0", bus.imem_req); end
    nvec++; if (currentpc !== 64'h14) begin nerr++; $display("FAIL ri_r_pc got %h want 14", currentpc); end
    nxt();
    bus.redirect = 1'b0;
    look();
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL ri_r1_valid got %b want 0", bus.if_valid); end
    nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h40) begin nerr++; $display("FAIL ri_r1_req got %b/%h want 1/40", bus.imem_req, bus.imem_addr); end
    nxt(); look();
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL ri_r2_valid got %b want 0", bus.if_valid); end
    nxt(); look();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h40) begin nerr++; $display("FAIL ri_r3_head got %b/%h want 1/40", bus.if_valid, bus.if_pc); end
    nvec++; if (bus.if_instr !== 32'hE000_0040) begin nerr++; $display("FAIL ri_r3_instr got %h want e0000040", bus.if_instr); end
    nxt(); look();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h44) begin nerr++; $display("FAIL ri_r4_head got %b/%h want 1/44", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_redirect_pop();
    int consumed;
    consumed = 0;
    start(64'h0);
    repeat (5) nxt();
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h100;
    look();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h8) begin nerr++; $display("FAIL rp_r_head got %b/%h want 1/8", bus.if_valid, bus.if_pc); end
    nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL rp_r_req got %b want 0", bus.imem_req); end
    if (bus.if_valid && bus.id_ready) consumed++;
    for (int c = 1; c <= 2; c++) begin
      nxt();
      bus.redirect = 1'b0;
      look();
      if (bus.if_valid && bus.id_ready) consumed++;
      nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL rp_r%0d_valid got %b want 0", c, bus.if_valid); end
      if (c == 1) begin
        nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100) begin nerr++; $display("FAIL rp_r1_req got %b/%h want 1/100", bus.imem_req, bus.imem_addr); end
      end
    end
    nvec++; if (consumed !== 1) begin nerr++; $display("FAIL rp_consumed got %0d want 1", consumed); end
    nxt(); look();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h100) begin nerr++; $display("FAIL rp_r3_head got %b/%h want 1/100", bus.if_valid, bus.if_pc); end
    nxt(); look();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h104) begin nerr++; $display("FAIL rp_r4_head got %b/%h want 1/104", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_back_to_back();
    start(64'h0);
    repeat (4) nxt();
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h200;
    nxt();
    bus.redirect_pc = 64'h302;
    look();
    nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL bb_2nd_req got %b want 0", bus.imem_req); end
    nxt();
    bus.redirect = 1'b0;
    look();
    nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h300) begin nerr++; $display("FAIL bb_req got %b/%h want 1/300", bus.imem_req, bus.imem_addr); end
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL bb_valid got %b want 0", bus.if_valid); end
    nxt(); look();
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL bb_valid2 got %b want 0", bus.if_valid); end
    nxt(); look();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h300) begin nerr++; $display("FAIL bb_head got %b/%h want 1/300", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_wrap();
    start(64'hFFFF_FFFF_FFFF_FFF8);
    nxt(); look();
    nvec++; if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin nerr++; $display("FAIL w_addr1 got %h want fffffffffffffff8", bus.imem_addr); end
    nxt(); look();
    nvec++; if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin nerr++; $display("FAIL w_addr2 got %h want fffffffffffffffc", bus.imem_addr); end
    nxt(); look();
    nvec++; if (bus.imem_addr !== 64'h0 || currentpc !== 64'h0) begin nerr++; $display("FAIL w_addr3 got %h/%h want 0/0", bus.imem_addr, currentpc); end
    nvec++; if (bus.if_pc !== 64'hFFFF_FFFF_FFFF_FFF8 || bus.if_instr !== 32'hE0FF_FFF8) begin nerr++; $display("FAIL w_h0 got %h/%h want fffffffffffffff8/e0fffff8", bus.if_pc, bus.if_instr); end
    nxt(); look();
    nvec++; if (bus.if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus.if_instr !== 32'hE0FF_FFFC) begin nerr++; $display("FAIL w_h1 got %h/%h want fffffffffffffffc/e0fffffc", bus.if_pc, bus.if_instr); end
    nxt(); look();
    nvec++; if (bus.if_pc !== 64'h0 || bus.if_instr !== 32'hE000_0000) begin nerr++; $display("FAIL w_h2 got %h/%h want 0/e0000000", bus.if_pc, bus.if_instr); end
    nxt(); look();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h4) begin nerr++; $display("FAIL w_h3 got %b/%h want 1/4", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_mid_reset();
    start(64'h0);
    repeat (5) nxt();
    look();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h8) begin nerr++; $display("FAIL mr_pre got %b/%h want 1/8", bus.if_valid, bus.if_pc); end
    nxt();
    startpc = 64'h20;
    reset = 1'b1;
    #1;
    nvec++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin nerr++; $display("FAIL mr_async got %b/%b want 0/0", bus.if_valid, bus.imem_req); end
    nvec++; if (currentpc !== 64'h20 || bus.if_pc !== 64'h0) begin nerr++; $display("FAIL mr_pc got %h/%h want 20/0", currentpc, bus.if_pc); end
    nxt();
    reset = 1'b0;
    look();
    nvec++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin nerr++; $display("FAIL mr_boot got %b/%b want 0/0", bus.imem_req, bus.if_valid); end
    nxt(); look();
    nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h20 || bus.if_valid !== 1'b0) begin nerr++; $display("FAIL mr_c1 got %b/%h/%b want 1/20/0", bus.imem_req, bus.imem_addr, bus.if_valid); end
    nxt(); look();
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL mr_c2_valid got %b want 0", bus.if_valid); end
    nxt(); look();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h20 || bus.if_instr !== 32'hE000_0020) begin nerr++; $display("FAIL mr_c3 got %b/%h/%h want 1/20/e0000020", bus.if_valid, bus.if_pc, bus.if_instr); end
  endtask

  initial begin
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pop();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors, want completion", nvec);
    $fatal(1);
  end
endmodule
